// File: rtl/mdu_pkg.sv
// Shared MDU types: divider op encodings, divider FSM states and the datapath width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

    localparam int XLEN_C = 32;

    // funct3[1:0] of the RISC-V M-extension divide/remainder ops
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } mdu_div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    // Signed ops have funct3[0] clear
    function automatic logic op_is_signed(input mdu_div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    // Remainder ops have funct3[1] set
    function automatic logic op_is_rem(input mdu_div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/radix_2_div.sv
// Sequential 32-bit restoring divider for DIV/DIVU/REM/REMU on operand magnitudes.
// Latency: 33 cycles from accept to valid (32 steps + sign fix-up); special cases 1 cycle.
// Backpressure: result held in DONE while cpu_busy is high; requests accepted only in IDLE.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   div_in_valid        request strobe, sampled only in IDLE
//   div_type            funct3[1:0]: DIV, DIVU, REM, REMU
//   dividend, divisor   operands, latched on accept
//   cpu_busy            consumer stall, holds the result in DONE
//   div_out             registered quotient or remainder
//   div_out_valid       result valid (DONE)
//   div_busy            high whenever the FSM is not IDLE
module radix_2_div
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_C
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_in_valid,
    input  logic [1:0]      div_type,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            cpu_busy,
    output logic [XLEN-1:0] div_out,
    output logic            div_out_valid,
    output logic            div_busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state;
    mdu_div_op_e      op_q;
    logic             dividend_neg_q;
    logic             divisor_neg_q;
    logic             special_q;
    logic [XLEN-1:0]  divisor_mag_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [CNT_W-1:0] cnt_q;

    // Request decode, used only when accepting in IDLE
    mdu_div_op_e     op_in;
    logic            signed_in;
    logic [XLEN-1:0] dividend_mag;
    logic [XLEN-1:0] divisor_mag;
    logic            div_by_zero;
    logic            overflow;

    always_comb begin
        op_in        = mdu_div_op_e'(div_type);
        signed_in    = op_is_signed(op_in);
        dividend_mag = (signed_in && dividend[XLEN-1]) ? -dividend : dividend;
        divisor_mag  = (signed_in && divisor[XLEN-1])  ? -divisor  : divisor;
        div_by_zero  = (divisor == '0);
        overflow     = signed_in && (dividend == MOST_NEG) && (divisor == '1);
    end

    // One restoring step. The partial remainder plus the incoming quotient bit
    // can need XLEN+1 bits, so the trial subtraction keeps the extra bit.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, divisor_mag_q};
        rem_nxt = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], ~trial[XLEN]};
    end

    // Sign fix-up applied to the magnitude results
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        quo_fix = ((op_q == DIV) && (dividend_neg_q ^ divisor_neg_q)) ? -quo_q : quo_q;
        rem_fix = ((op_q == REM) && dividend_neg_q) ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            op_q           <= DIV;
            dividend_neg_q <= 1'b0;
            divisor_neg_q  <= 1'b0;
            special_q      <= 1'b0;
            divisor_mag_q  <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            cnt_q          <= '0;
            div_out        <= '0;
            div_out_valid  <= 1'b0;
            div_busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_in_valid) begin
                        op_q           <= op_in;
                        dividend_neg_q <= signed_in & dividend[XLEN-1];
                        divisor_neg_q  <= signed_in & divisor[XLEN-1];
                        divisor_mag_q  <= divisor_mag;
                        rem_q          <= '0;
                        cnt_q          <= '0;
                        div_busy       <= 1'b1;
                        // Special cases park the final answer in quo_q and
                        // skip the iteration; FIX then just registers it.
                        if (div_by_zero) begin
                            special_q <= 1'b1;
                            quo_q     <= op_is_rem(op_in) ? dividend : '1;
                            state     <= FIX;
                        end else if (overflow) begin
                            special_q <= 1'b1;
                            quo_q     <= op_is_rem(op_in) ? '0 : MOST_NEG;
                            state     <= FIX;
                        end else begin
                            special_q <= 1'b0;
                            quo_q     <= dividend_mag;
                            state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (special_q) begin
                        div_out <= quo_q;
                    end else begin
                        div_out <= op_is_rem(op_q) ? rem_fix : quo_fix;
                    end
                    div_out_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (!cpu_busy) begin
                        div_out_valid <= 1'b0;
                        div_busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_radix_2_div.sv
// Self-checking bench for radix_2_div: vector table, random ops against a
// reference model, and hand-written stall / abort / back-to-back sequences.
module tb_radix_2_div;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         div_in_valid;
    logic [1:0]   div_type;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         cpu_busy;
    logic [W-1:0] div_out;
    logic         div_out_valid;
    logic         div_busy;

    always #5 clk = ~clk;

    radix_2_div #(.XLEN(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_in_valid (div_in_valid),
        .div_type     (div_type),
        .dividend     (dividend),
        .divisor      (divisor),
        .cpu_busy     (cpu_busy),
        .div_out      (div_out),
        .div_out_valid(div_out_valid),
        .div_busy     (div_busy)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: language division with the RISC-V special-case rules
    function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic sgn;
        sgn = !op[0];
        if (b == '0) return op[1] ? a : '1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? '0 : a;
        if (sgn) return op[1] ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
        return op[1] ? a % b : a / b;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        if (b == '0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Scoreboard: a result is consumed in any valid cycle with cpu_busy low
    always @(negedge clk) begin
        if (rst && div_out_valid && !cpu_busy) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_valid: got %h want no result", div_out);
            end else begin
                check("result", div_out, exp_q.pop_front());
            end
        end
    end

    // Drives one request; returns #1 after the accept edge with operands scrambled
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] e);
        div_type     = op;
        dividend     = a;
        divisor      = b;
        div_in_valid = 1'b1;
        @(posedge clk);
        #1;
        div_in_valid = 1'b0;
        dividend     = $urandom;
        divisor      = $urandom;
        div_type     = 2'($urandom_range(0, 3));
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(output int lat, inout int busy_cnt);
        lat = 0;
        while (!div_out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            busy_cnt += int'(div_busy);
        end
        if (!div_out_valid) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got no valid want valid within 100 cycles");
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e, input int exp_lat, output int busy_cnt);
        int lat;
        start_op(op, a, b, e);
        busy_cnt = int'(div_busy);
        wait_valid(lat, busy_cnt);
        check("latency", W'(lat), W'(exp_lat));
        @(posedge clk);
        #1;
        busy_cnt += int'(div_busy);
        check("valid_one_cycle", W'(div_out_valid), W'(0));
    endtask

    initial begin
        int bc;
        int lat;
        logic [W-1:0] held;
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst          = 1'b0;
        div_in_valid = 1'b0;
        div_type     = 2'b00;
        dividend     = '0;
        divisor      = '0;
        cpu_busy     = 1'b0;

        vecs[0]  = '{DIV,  32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{REM,  32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[3]  = '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
        vecs[5]  = '{REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          33};
        vecs[6]  = '{DIV,  32'h1234,       32'd0,          32'hFFFF_FFFF,  1};
        vecs[7]  = '{REM,  32'h1234,       32'd0,          32'h1234,       1};
        vecs[8]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[9]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[10] = '{DIVU, 32'h1234,       32'd0,          32'hFFFF_FFFF,  1};
        vecs[11] = '{REMU, 32'h1234,       32'd0,          32'h1234,       1};
        vecs[12] = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
        vecs[13] = '{DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
        vecs[14] = '{REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};

        repeat (2) @(posedge clk);
        #1;
        check("reset_div_out", div_out, '0);
        check("reset_valid", W'(div_out_valid), W'(0));
        check("reset_busy", W'(div_busy), W'(0));
        rst = 1'b1;

        // Table vectors, issued back to back
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat, bc);
            if (i == 0) check("busy_cycles", W'(bc), W'(34));
        end

        // Random ops against the reference model
        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 2 == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
            if (i % 3 == 0) ra = -ra;
            run_op(rop, ra, rb, ref_div(rop, ra, rb), ref_lat(rop, ra, rb), bc);
        end

        // Stall at completion, plus an ignored request during CALC
        start_op(DIV, 32'd1000, 32'hFFFF_FFFD, ref_div(DIV, 32'd1000, 32'hFFFF_FFFD));
        cpu_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        div_type     = REMU;
        dividend     = 32'd55;
        divisor      = 32'd4;
        div_in_valid = 1'b1;
        @(posedge clk);
        #1;
        div_in_valid = 1'b0;
        bc = 0;
        wait_valid(lat, bc);
        held = div_out;
        check("stall_result", held, 32'hFFFF_FEB3);
        for (int k = 1; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_valid", W'(div_out_valid), W'(1));
            check("stall_stable", div_out, held);
        end
        cpu_busy = 1'b0;
        check("release_valid", W'(div_out_valid), W'(1));
        @(posedge clk);
        #1;
        check("after_release_valid", W'(div_out_valid), W'(0));
        check("after_release_busy", W'(div_busy), W'(0));

        // Reset in the middle of CALC aborts without a result
        start_op(DIVU, 32'hDEAD_BEEF, 32'h13, 32'h0);
        void'(exp_q.pop_back());
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_div_out", div_out, '0);
        check("abort_valid", W'(div_out_valid), W'(0));
        check("abort_busy", W'(div_busy), W'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        run_op(DIVU, 32'd9, 32'd3, 32'd3, 33, bc);

        // Back-to-back: second accept in the cycle right after DONE
        run_op(DIV, 32'hFFFF_FF00, 32'd16, 32'hFFFF_FFF0, 33, bc);
        run_op(REMU, 32'd1001, 32'd10, 32'd1, 33, bc);

        // Idle window: no stray valid may appear
        repeat (40) @(posedge clk);
        #1;
        check("queue_empty", W'(exp_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish before 500us");
        $fatal(1, "timeout");
    end

endmodule
